shift_register_universal: RTL
=============================

SHIFT_REGISTER_UNIVERSAL -- requirements
Module: shift_register_universal

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 8, register width in bits (minimum 2).
REQ-002 The block SHALL have parameter COUNT_WIDTH, default $clog2(WORD_LENGTH)+1, width of the shift-amount field.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port sys_reset, input, 1, synchronous active-high clear.
REQ-006 The block SHALL have port load, input, 1, parallel load request.
REQ-007 The block SHALL have port shift, input, 1, single-step shift request.
REQ-008 The block SHALL have port start, input, 1, multi-step shift request.
REQ-009 The block SHALL have port mode, input, 2, operation select: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
REQ-010 The block SHALL have port amount, input, COUNT_WIDTH, number of steps for a start request.
REQ-011 The block SHALL have port serialInput, input, 1, fill bit for modes 00 and 01.
REQ-012 The block SHALL have port parallelInput, input, WORD_LENGTH, load data.
REQ-013 The block SHALL have port serialOutput, output, 1, next bit to leave: MSB for modes 00 and 11, LSB for modes 01 and 10, using the live mode in IDLE and the latched mode in RUN.
REQ-014 The block SHALL have port parallelOutput, output, WORD_LENGTH, register contents.
REQ-015 The block SHALL have port busy, output, 1, high while in RUN.
REQ-016 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-017 Single step per mode: 00 = {R[W-2:0], serialInput}; 01 = {serialInput, R[W-1:1]}; 10 = {R[W-1], R[W-1:1]}; 11 = {R[W-2:0], R[W-1]}.
REQ-018 FSM SHALL have two states, IDLE and RUN, with done driven from a register.
REQ-019 Priority in IDLE SHALL be sys_reset > load > start > shift; lower-priority requests in the same cycle are dropped.
REQ-020 In IDLE, load SHALL write parallelInput in 1 cycle; shift SHALL perform one step of the live mode in 1 cycle; neither asserts done.
REQ-021 In IDLE, start with amount N>0 at edge k SHALL latch mode and N and enter RUN. Steps occur at edges k+1..k+N. Return to IDLE is at edge k+N.
REQ-022 busy SHALL be high from edge k to edge k+N (N cycles). done SHALL be high for exactly the one cycle after edge k+N.
REQ-023 start with amount 0 SHALL leave R unchanged, never raise busy, and raise done for the one cycle after edge k.
REQ-024 In RUN, load, shift, start, mode and amount SHALL be ignored; serialInput SHALL be sampled at each step edge.
REQ-025 Amounts greater than WORD_LENGTH SHALL be honoured step by step: rotate wraps; logical and arithmetic modes saturate to fill or sign.
REQ-026 sys_reset in any state SHALL clear R, return to IDLE, clear the counter and deassert busy and done at the next edge; an aborted run SHALL never pulse done.
REQ-027 A start arriving in the cycle done is high SHALL be accepted (back-to-back operation).

Reset
REQ-028 reset low SHALL immediately force parallelOutput=0, serialOutput=0, busy=0, done=0, state IDLE, counter 0 and latched mode 00, regardless of clk.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new request on the first edge.

Verification
REQ-030 W=8: load 0xB4, start mode 00 amount 3 serialInput 0 -> 0xA0; busy high 3 cycles; done high 1 cycle after the 3rd step.
REQ-031 W=8: load 0x96, start mode 10 amount 2 -> 0xE5; then start mode 01 amount 8 serialInput 1 -> 0xFF.
REQ-032 W=8: load 0x81, start mode 11 amount 9 -> 0x03; serialOutput=0 at completion.
REQ-033 start amount 0 -> R unchanged, busy stays 0, done high for exactly 1 cycle; a start in the done cycle is accepted.
REQ-034 Mid-RUN: toggle load/shift/mode -> no effect; sys_reset -> R=0, busy=0, no done; async reset in a separate run -> immediate zeros.

Source files
------------

// File: rtl/shift_register_universal.sv
// shift_register_universal: loadable W-bit register with single-step and counted multi-step shifts in four modes
module shift_register_universal #(
    parameter int WORD_LENGTH = 8,
    parameter int COUNT_WIDTH = $clog2(WORD_LENGTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sys_reset,
    input  logic                   load,
    input  logic                   shift,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [COUNT_WIDTH-1:0] amount,
    input  logic                   serialInput,
    input  logic [WORD_LENGTH-1:0] parallelInput,
    output logic                   serialOutput,
    output logic [WORD_LENGTH-1:0] parallelOutput,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t                 state, state_d;
    logic [WORD_LENGTH-1:0] r;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [1:0]             mode_q, eff_mode;
    logic                   done_q, done_d, accept_start, last_step;

    function automatic logic [WORD_LENGTH-1:0] step(input logic [1:0] m, input logic [WORD_LENGTH-1:0] v, input logic si);
        return m == 2'b00 ? {v[WORD_LENGTH-2:0], si} :
               m == 2'b01 ? {si, v[WORD_LENGTH-1:1]} :
               m == 2'b10 ? {v[WORD_LENGTH-1], v[WORD_LENGTH-1:1]} :
                            {v[WORD_LENGTH-2:0], v[WORD_LENGTH-1]};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        accept_start = state == IDLE && !sys_reset && !load && start;
        last_step    = state == RUN && cnt == COUNT_WIDTH'(1);
        state_d      = sys_reset ? IDLE :
                       state == IDLE ? ((accept_start && amount != '0) ? RUN : IDLE) :
                       (last_step ? IDLE : RUN);
        done_d       = !sys_reset && ((accept_start && amount == '0) || last_step);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r      <= '0;
            cnt    <= '0;
            mode_q <= 2'b00;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (sys_reset) begin
                r   <= '0;
                cnt <= '0;
            end else if (state == RUN) begin
                r   <= step(mode_q, r, serialInput);
                cnt <= cnt - COUNT_WIDTH'(1);
            end else if (load) begin
                r <= parallelInput;
            end else if (start) begin
                if (amount != '0) begin
                    mode_q <= mode;
                    cnt    <= amount;
                end
            end else if (shift) begin
                r <= step(mode, r, serialInput);
            end
        end
    end

    // the outgoing bit follows the mode that will drive the next step
    always_comb begin
        busy           = state == RUN;
        eff_mode       = busy ? mode_q : mode;
        serialOutput   = (eff_mode[1] == eff_mode[0]) ? r[WORD_LENGTH-1] : r[0];
        parallelOutput = r;
        done           = done_q;
    end
endmodule
